// File: rtl/sa_ext_stream_ctrl.sv
// sa_ext_stream_ctrl
//   Streaming external-mode front end for the systolic array. Input/weight
//   beats arrive over a valid/ready handshake and are forwarded to the array's
//   west/north buses with load/sum_out strobes. After each group of K compute
//   beats, the array's south result is captured RES_LAT cycles later into a
//   small result FIFO. That FIFO drains over a valid/ready master port.
//
// Ports
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   en_i, clear_i       block enable, synchronous flush
//   k_len_i             compute beats per group (latched on the group's first beat)
//   s_valid_i/s_ready_o input handshake; s_wload_i marks weight-load beats
//   s_input_i/s_weight_i beat data
//   sa_west_o/sa_north_o/sa_load_o/sa_sum_out_o  array drive
//   sa_south_i          array result bus
//   m_valid_o/m_ready_i/m_data_o  result master port
//   busy_o, beat_cnt_o  status
module sa_ext_stream_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ROW        = 4,
    parameter int unsigned COL        = 4,
    parameter int unsigned K_MAX      = 16,
    parameter int unsigned RES_LAT    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         en_i,
    input  logic                         clear_i,
    input  logic [$clog2(K_MAX+1)-1:0]   k_len_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic                         s_wload_i,
    input  logic [ROW*WIDTH-1:0]         s_input_i,
    input  logic [COL*WIDTH-1:0]         s_weight_i,
    output logic [ROW*WIDTH-1:0]         sa_west_o,
    output logic [COL*WIDTH-1:0]         sa_north_o,
    output logic [ROW*COL-1:0]           sa_load_o,
    output logic [ROW*COL-1:0]           sa_sum_out_o,
    input  logic [COL*WIDTH-1:0]         sa_south_i,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic [COL*WIDTH-1:0]         m_data_o,
    output logic                         busy_o,
    output logic [$clog2(K_MAX+1)-1:0]   beat_cnt_o
);

    localparam int unsigned KW = $clog2(K_MAX + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [KW-1:0] KMAX_C  = KW'(K_MAX);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACC} state_t;

    state_t               state_q, state_d;
    logic [KW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [KW-1:0]        klen_q, klen_in, klen_eff;
    logic [RES_LAT-1:0]   pipe_q, pipe_d;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [COL*WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [CW:0]          credit_used;
    logic                 fire, compute, close, push, pop;

    // Results already buffered plus results still in the array must fit in
    // the FIFO, so a pipe exit can never find it full.
    assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign s_ready_o   = en_i & ~clear_i & (credit_used < DEPTH_C);

    assign m_valid_o  = (fifo_cnt_q != '0);
    assign m_data_o   = mem_q[rd_ptr_q];
    assign busy_o     = (state_q == ACC) | (inflight_q != '0) | (fifo_cnt_q != '0);
    assign beat_cnt_o = beat_cnt_q;

    always_comb begin
        if (k_len_i == '0)
            klen_in = KW'(1);
        else if (k_len_i > KMAX_C)
            klen_in = KMAX_C;
        else
            klen_in = k_len_i;
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        pipe_d     = pipe_q << 1;

        fire    = s_valid_i & s_ready_o;
        compute = fire & ~s_wload_i;
        // The first beat of a group compares against the freshly clamped
        // length, so a length of 1 closes without ever entering ACC.
        klen_eff = (state_q == IDLE) ? klen_in : klen_q;
        close    = compute & ((beat_cnt_q + KW'(1)) == klen_eff);
        push     = pipe_q[RES_LAT-1];
        pop      = m_valid_o & m_ready_i;

        sa_west_o    = fire ? s_input_i  : '0;
        sa_north_o   = fire ? s_weight_i : '0;
        sa_load_o    = (fire & s_wload_i) ? '1 : '0;
        sa_sum_out_o = compute ? '1 : '0;

        if (compute) begin
            if (close) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end else begin
                state_d    = ACC;
                beat_cnt_d = beat_cnt_q + KW'(1);
            end
        end
        pipe_d[0] = close;

        case ({close, push})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        if (clear_i) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            pipe_d     = '0;
            inflight_d = '0;
            fifo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            beat_cnt_q <= '0;
            klen_q     <= KW'(1);
            pipe_q     <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            pipe_q     <= pipe_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (compute && state_q == IDLE)
                    klen_q <= klen_in;
                if (push) begin
                    mem_q[wr_ptr_q] <= sa_south_i;
                    wr_ptr_q        <= wr_ptr_q + PW'(1);
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

endmodule
